text_buffer_writer: RTL and testbench
=====================================

// Module: text_buffer_writer
// PURPOSE
//  Consumes decoded ASCII key events from the PS/2 decode stage and writes them into the
//  character RAM read by the VGA character display. Maintains cursor, line wrap, newline,
//  backspace, form-feed clear and ring-buffer scrolling via a top_row offset the display
//  adds to its row index. Sits between PS/2 ASCII decode and the char RAM write port.
// PARAMETERS
//  COLS    70  characters per text row
//  ROWS    30  text rows on screen
//  ADDR_W  12  char RAM address width; must satisfy 2**ADDR_W >= COLS*ROWS
// PORTS
//  clk         in   1       system clock
//  clrn        in   1       asynchronous active-low reset
//  key_valid   in   1       ASCII event valid; source holds key_ascii until accepted
//  key_ascii   in   8       ASCII code of pressed key (make events only)
//  key_ready   out  1       high when an event can be accepted this cycle
//  wr_en       out  1       char RAM write strobe, one cycle per write
//  wr_addr     out  ADDR_W  char RAM address = phys_row*COLS + col
//  wr_data     out  8       char RAM write data
//  cursor_x    out  7       current column, 0..COLS-1
//  cursor_y    out  5       current logical row, 0..ROWS-1
//  top_row     out  5       physical RAM row shown at screen row 0
// BEHAVIOUR
//  - Reset: wr_en=0, wr_addr=0, wr_data=0, cursor_x=0, cursor_y=0, top_row=0,
//    key_ready=0, state=CLR_ALL. Reset is async and aborts any operation in progress.
//  - phys_row = (top_row + row) mod ROWS, computed without a divider (compare/subtract).
//  - States: IDLE, CLR_LINE, CLR_ALL. key_ready = (state==IDLE). Accept = key_valid & key_ready.
//  - All outputs are registered; a write appears on wr_en exactly 1 cycle after the accepting edge.
//  - IDLE accepts back-to-back events every cycle.
//  - Printable 0x20..0x7E: write char at (cursor_x,cursor_y); cursor_x+1. If cursor_x was
//    COLS-1: cursor_x=0 and line feed.
//  - 0x0D (Enter): no write; cursor_x=0; line feed.
//  - 0x08 (Backspace): if x>0, x-1; elif y>0, x=COLS-1, y-1; then write 0x20 at the new position.
//    At (0,0): ignored, no write.
//  - 0x0C (Form feed): go to CLR_ALL.
//  - All other codes: accepted and discarded, no write, no cursor change.
//  - Line feed:
//    - If cursor_y<ROWS-1: cursor_y+1.
//    - Else cursor_y stays ROWS-1; top_row=(top_row+1) mod ROWS; enter CLR_LINE.
//  - CLR_LINE: writes 0x20 to cols 0..COLS-1 of the new bottom physical row (the old top_row),
//    one per cycle, COLS cycles. Then returns to IDLE.
//  - CLR_ALL: writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle. Then cursor=(0,0),
//    top_row=0, IDLE.
//  - Both clear states hold key_ready=0 throughout; a held key_valid is accepted on the first
//    IDLE cycle.
//  - A printable char at (COLS-1,ROWS-1) is written first, then the scroll clear begins.
//  - Addresses never exceed COLS*ROWS-1. Counters saturate/wrap exactly at the COLS/ROWS bounds,
//    never at the power-of-2 bound.
// TESTING
//  - Reset release -> 2100 consecutive wr_en pulses (addr 0..2099, data 0x20);
//    then key_ready=1, cursor (0,0).
//  - Keys 'A'(0x41),'B' held valid back-to-back -> writes addr0=0x41, addr1=0x42 on consecutive
//    cycles; cursor_x=2.
//  - 70 printable chars from (0,0) -> last written at addr 69; cursor (0,1);
//    then 0x08 -> space written at addr 69, cursor (69,0).
//  - Cursor at row 29, 0x0D -> top_row 0->1; 70 writes of 0x20 at addr 0..69; key_ready low
//    70 cycles; cursor (0,29).
//  - With top_row=1, 'Z' at (0,29) -> wr_addr=0 (phys row 0); 0x08 at (0,0) -> no write.
//  - clrn asserted mid CLR_LINE -> outputs at reset values immediately; full CLR_ALL restarts
//    on release.

Source files
------------

// File: rtl/text_buffer_writer.sv
// text_buffer_writer
//   Turns decoded ASCII key events into character RAM writes for the VGA text
//   display. Keeps the cursor, wraps long lines, handles Enter, Backspace and
//   form-feed clear, and scrolls by rotating top_row. The display adds top_row
//   to its row index, so a scroll only has to blank one physical row.
//
// Ports
//   clk        in   system clock
//   clrn       in   asynchronous active-low reset
//   key_valid  in   ASCII event valid; source holds key_ascii until accepted
//   key_ascii  in   ASCII code (make events only)
//   key_ready  out  an event can be accepted this cycle (IDLE only)
//   wr_en      out  char RAM write strobe, one cycle per write
//   wr_addr    out  char RAM address = phys_row*COLS + col
//   wr_data    out  char RAM write data
//   cursor_x   out  current column 0..COLS-1
//   cursor_y   out  current logical row 0..ROWS-1
//   top_row    out  physical RAM row shown at screen row 0
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | accepting key events, one per cycle
// CLR_LINE | blanking the physical row that just became the bottom line
// CLR_ALL  | blanking the whole screen (after reset or form feed)

module text_buffer_writer #(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              key_valid,
    input  logic [7:0]        key_ascii,
    output logic              key_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic [4:0]        top_row
);

    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

    localparam logic [7:0]        SPACE     = 8'h20;
    localparam logic [6:0]        X_MAX     = 7'(COLS - 1);
    localparam logic [4:0]        Y_MAX     = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ALL_LAST  = ADDR_W'(COLS * ROWS - 1);

    // (top + row) mod ROWS; both operands are < ROWS so one subtract suffices.
    function automatic logic [4:0] phys_row(input logic [4:0] top, input logic [4:0] row);
        logic [5:0] s;
        s = {1'b0, top} + {1'b0, row};
        if (s >= 6'(ROWS))
            s = s - 6'(ROWS);
        return s[4:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
        return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    state_t            r_state;
    logic              r_key_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [6:0]        r_x;
    logic [4:0]        r_y;
    logic [4:0]        r_top;
    logic [ADDR_W-1:0] r_clr_addr;   // next address the clear states write
    logic [ADDR_W-1:0] r_clr_cnt;    // writes remaining minus one

    logic              w_accept;
    logic              w_printable;
    logic              w_enter;
    logic              w_bs;
    logic              w_ff;
    logic              w_bs_ok;
    logic [6:0]        w_bs_x;
    logic [4:0]        w_bs_y;
    logic              w_line_feed;
    logic [4:0]        w_top_inc;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [ADDR_W-1:0] w_bs_addr;
    logic [ADDR_W-1:0] w_line_base;

    assign w_accept    = key_valid & r_key_ready;
    assign w_printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
    assign w_enter     = (key_ascii == 8'h0D);
    assign w_bs        = (key_ascii == 8'h08);
    assign w_ff        = (key_ascii == 8'h0C);

    assign w_bs_ok = (r_x != 7'd0) || (r_y != 5'd0);
    assign w_bs_x  = (r_x != 7'd0) ? r_x - 7'd1 : X_MAX;
    assign w_bs_y  = (r_x != 7'd0) ? r_y : r_y - 5'd1;

    // Line feed comes from Enter or from a printable char in the last column.
    assign w_line_feed = w_enter || (w_printable && (r_x == X_MAX));
    assign w_top_inc   = (r_top == Y_MAX) ? 5'd0 : r_top + 5'd1;

    assign w_cur_addr  = cell_addr(phys_row(r_top, r_y), r_x);
    assign w_bs_addr   = cell_addr(phys_row(r_top, w_bs_y), w_bs_x);
    // On scroll the old top row becomes the new bottom row.
    assign w_line_base = cell_addr(r_top, 7'd0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= CLR_ALL;
            r_key_ready <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_x         <= 7'd0;
            r_y         <= 5'd0;
            r_top       <= 5'd0;
            r_clr_addr  <= '0;
            r_clr_cnt   <= ALL_LAST;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_cur_addr;
                            r_wr_data <= key_ascii;
                            r_x       <= (r_x == X_MAX) ? 7'd0 : r_x + 7'd1;
                        end else if (w_enter) begin
                            r_x <= 7'd0;
                        end else if (w_bs) begin
                            if (w_bs_ok) begin
                                r_x       <= w_bs_x;
                                r_y       <= w_bs_y;
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= w_bs_addr;
                                r_wr_data <= SPACE;
                            end
                        end else if (w_ff) begin
                            r_state     <= CLR_ALL;
                            r_key_ready <= 1'b0;
                            r_clr_addr  <= '0;
                            r_clr_cnt   <= ALL_LAST;
                        end

                        if (w_line_feed) begin
                            if (r_y != Y_MAX) begin
                                r_y <= r_y + 5'd1;
                            end else begin
                                r_top       <= w_top_inc;
                                r_state     <= CLR_LINE;
                                r_key_ready <= 1'b0;
                                r_clr_addr  <= w_line_base;
                                r_clr_cnt   <= LINE_LAST;
                            end
                        end
                    end
                end

                CLR_LINE, CLR_ALL: begin
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= r_clr_addr;
                    r_wr_data  <= SPACE;
                    r_clr_addr <= r_clr_addr + 1'b1;
                    r_clr_cnt  <= r_clr_cnt - 1'b1;
                    if (r_clr_cnt == '0) begin
                        r_state     <= IDLE;
                        r_key_ready <= 1'b1;
                        if (r_state == CLR_ALL) begin
                            r_x   <= 7'd0;
                            r_y   <= 5'd0;
                            r_top <= 5'd0;
                        end
                    end
                end

                default: begin
                    r_state     <= CLR_ALL;
                    r_key_ready <= 1'b0;
                    r_clr_addr  <= '0;
                    r_clr_cnt   <= ALL_LAST;
                end
            endcase
        end
    end

    assign key_ready = r_key_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cursor_x  = r_x;
    assign cursor_y  = r_y;
    assign top_row   = r_top;

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_ascii = 8'h00;
    logic        key_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [4:0]  top_row;

    text_buffer_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12)) dut (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_ascii(key_ascii),
        .key_ready(key_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .top_row(top_row)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Shadow of the char RAM built from observed writes; sampled 1 time unit
    // after the edge so tasks working on the falling edge see settled counts.
    logic [7:0] dut_ram [CELLS];
    int wr_count  = 0;
    int bad_addr  = 0;
    int last_addr = 0;
    int last_data = 0;
    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            wr_count++;
            last_addr = int'(wr_addr);
            last_data = int'(wr_data);
            if (int'(wr_addr) < CELLS) dut_ram[wr_addr] = wr_data;
            else bad_addr++;
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (key_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (key_ready !== 1'b1) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic send_key(input logic [7:0] k);
        @(negedge clk);
        wait_ready("send");
        key_valid = 1'b1;
        key_ascii = k;
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_and_settle(input logic [7:0] k);
        send_key(k);
        wait_ready("settle");
    endtask

    // Called while clrn is low: checks reset values, releases reset and
    // checks the full-screen clear sequence.
    task automatic reset_and_clear(input string name);
        int err;
        chk({name, "_rst_wr_en"}, wr_en, 0);
        chk({name, "_rst_outs"}, {wr_addr, wr_data, cursor_x, cursor_y, top_row, key_ready}, 0);
        @(negedge clk);
        clrn = 1'b1;
        err = 0;
        for (int i = 0; i < CELLS; i++) begin
            @(negedge clk);
            if (wr_en !== 1'b1 || int'(wr_addr) != i || wr_data !== 8'h20) err++;
        end
        chk({name, "_clr_all_seq_errs"}, err, 0);
        @(negedge clk);
        chk({name, "_after_clr_wr_en"}, wr_en, 0);
        chk({name, "_after_clr_ready"}, key_ready, 1);
        chk({name, "_after_clr_cursor"}, {cursor_x, cursor_y, top_row}, 0);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_ram [CELLS];
    int mx, my, mtop;

    function automatic int m_addr(int row, int col);
        return ((mtop + row) % ROWS) * COLS + col;
    endfunction

    task automatic m_line_feed();
        if (my < ROWS - 1) my++;
        else begin
            for (int c = 0; c < COLS; c++) m_ram[mtop * COLS + c] = 8'h20;
            mtop = (mtop + 1) % ROWS;
        end
    endtask

    task automatic m_key(input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            m_ram[m_addr(my, mx)] = k;
            if (mx == COLS - 1) begin mx = 0; m_line_feed(); end
            else mx++;
        end else if (k == 8'h0D) begin
            mx = 0;
            m_line_feed();
        end else if (k == 8'h08) begin
            if (mx > 0 || my > 0) begin
                if (mx > 0) mx--;
                else begin mx = COLS - 1; my--; end
                m_ram[m_addr(my, mx)] = 8'h20;
            end
        end else if (k == 8'h0C) begin
            for (int a = 0; a < CELLS; a++) m_ram[a] = 8'h20;
            mx = 0; my = 0; mtop = 0;
        end
    endtask

    task automatic cmp_ram(input string name);
        int mism;
        mism = 0;
        for (int a = 0; a < CELLS; a++) if (dut_ram[a] !== m_ram[a]) mism++;
        chk(name, mism, 0);
    endtask

    typedef struct {
        logic [7:0] key;
        int nwr;
        int addr;
        int data;
        int x;
        int y;
        int top;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int err, low, nw, c0;
        logic [7:0] k;
        logic [7:0] others[7];

        // 1. reset and initial clear
        #23;
        reset_and_clear("init");

        // 2. back-to-back A, B held valid
        key_valid = 1'b1;
        key_ascii = 8'h41;
        @(posedge clk);
        #1 key_ascii = 8'h42;
        @(negedge clk);
        chk("b2b_first", {wr_en, wr_addr, wr_data}, {1'b1, 12'd0, 8'h41});
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second", {wr_en, wr_addr, wr_data}, {1'b1, 12'd1, 8'h42});
        chk("b2b_cursor_x", cursor_x, 2);

        // 3. table-driven single keys from (0,0)
        vecs[0]  = '{8'h41, 1, 0,  8'h41, 1,  0, 0};
        vecs[1]  = '{8'h42, 1, 1,  8'h42, 2,  0, 0};
        vecs[2]  = '{8'h0D, 0, 0,  0,     0,  1, 0};
        vecs[3]  = '{8'h08, 1, 69, 8'h20, 69, 0, 0};
        vecs[4]  = '{8'h08, 1, 68, 8'h20, 68, 0, 0};
        vecs[5]  = '{8'h01, 0, 0,  0,     68, 0, 0};
        vecs[6]  = '{8'h7E, 1, 68, 8'h7E, 69, 0, 0};
        vecs[7]  = '{8'h7F, 0, 0,  0,     69, 0, 0};
        vecs[8]  = '{8'h20, 1, 69, 8'h20, 0,  1, 0};
        vecs[9]  = '{8'h1F, 0, 0,  0,     0,  1, 0};
        vecs[10] = '{8'h71, 1, 70, 8'h71, 1,  1, 0};
        send_and_settle(8'h0C);
        foreach (vecs[i]) begin
            c0 = wr_count;
            send_and_settle(vecs[i].key);
            chk($sformatf("vec%0d_nwr", i), wr_count - c0, vecs[i].nwr);
            if (vecs[i].nwr > 0) begin
                chk($sformatf("vec%0d_addr", i), last_addr, vecs[i].addr);
                chk($sformatf("vec%0d_data", i), last_data, vecs[i].data);
            end
            chk($sformatf("vec%0d_cursor", i), {cursor_x, cursor_y, top_row},
                {7'(vecs[i].x), 5'(vecs[i].y), 5'(vecs[i].top)});
        end

        // 4. 70 chars wrap to next line, then backspace back over the wrap
        send_and_settle(8'h0C);
        for (int i = 0; i < COLS; i++) send_and_settle(8'h61 + 8'(i % 26));
        chk("wrap_last_addr", last_addr, 69);
        chk("wrap_last_data", last_data, 8'h72);
        chk("wrap_cursor", {cursor_x, cursor_y}, {7'd0, 5'd1});
        send_and_settle(8'h08);
        chk("wrap_bs_write", {last_addr, last_data}, {32'd69, 32'h20});
        chk("wrap_bs_cursor", {cursor_x, cursor_y}, {7'd69, 5'd0});

        // 5. backspace at (0,0) is ignored
        send_and_settle(8'h0C);
        c0 = wr_count;
        send_and_settle(8'h08);
        chk("bs_origin_nwr", wr_count - c0, 0);
        chk("bs_origin_cursor", {cursor_x, cursor_y}, 0);

        // 6. scroll with Enter at row 29, 'Z' held during the line clear
        for (int i = 0; i < ROWS - 1; i++) send_and_settle(8'h0D);
        chk("pre_scroll_cursor", {cursor_x, cursor_y, top_row}, {7'd0, 5'd29, 5'd0});
        key_valid = 1'b1;
        key_ascii = 8'h0D;
        @(posedge clk);
        #1 key_ascii = 8'h5A;
        low = 0; nw = 0; err = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                if (int'(wr_addr) != nw || wr_data !== 8'h20) err++;
                nw++;
            end
            if (key_ready === 1'b1) break;
            low++;
        end
        chk("scroll_ready_low_cycles", low, 70);
        chk("scroll_nwrites", nw, 70);
        chk("scroll_write_errs", err, 0);
        chk("scroll_cursor", {cursor_x, cursor_y, top_row}, {7'd0, 5'd29, 5'd1});
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(negedge clk);
        chk("held_z_write", {wr_en, wr_addr, wr_data}, {1'b1, 12'd0, 8'h5A});
        chk("held_z_cursor", {cursor_x, cursor_y, top_row}, {7'd1, 5'd29, 5'd1});

        // 7. randomized keys against the reference model
        others = '{8'h00, 8'h1B, 8'h7F, 8'h80, 8'hFF, 8'h0A, 8'h09};
        send_and_settle(8'h0C);
        m_key(8'h0C);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60)      k = 8'($urandom_range(32, 126));
            else if (r < 75) k = 8'h0D;
            else if (r < 90) k = 8'h08;
            else if (r < 98) k = others[$urandom_range(0, 6)];
            else             k = 8'h0C;
            send_and_settle(k);
            m_key(k);
            chk($sformatf("rand%0d_cursor", i), {cursor_x, cursor_y, top_row},
                {7'(mx), 5'(my), 5'(mtop)});
            if (i % 50 == 49) cmp_ram($sformatf("rand%0d_ram", i));
        end
        chk("addr_in_range", bad_addr, 0);

        // 8. reset in the middle of a line clear
        send_and_settle(8'h0C);
        for (int i = 0; i < ROWS - 1; i++) send_and_settle(8'h0D);
        send_key(8'h0D);
        repeat (10) @(negedge clk);
        chk("mid_clr_busy", key_ready, 0);
        @(posedge clk);
        #1 clrn = 1'b0;
        #1;
        chk("mid_rst_async", {wr_en, wr_addr, wr_data, cursor_x, cursor_y, top_row, key_ready}, 0);
        reset_and_clear("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
